ps2_kbd_rx: RTL
===============

# ps2_kbd_rx

PS/2 keyboard receiver and decoder that turns raw keyboard frames into single-byte ASCII key events. Its `kB` and `kclk` outputs drive the coprocessor-0 keyboard inputs of the same names. Downstream, `kB - 0x30` gives the digit value, and `kB == 8` means backspace. The block runs entirely in the `CLK` domain. The asynchronous PS/2 lines are synchronised internally.

## Interface
- `TIMEOUT_CYC`, default 50000: CLK cycles without a PS/2 falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
- `STRB_CYC`, default 4: length of the `kclk` strobe in CLK cycles; legal range 2–15.
- `CLK`  in  1  system clock. Single clock domain.
- `RST`  in  1  reset; synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `kB`  out  8  ASCII code of the last accepted key. Held until the next key.
- `kclk`  out  1  key strobe. High for `STRB_CYC` cycles per accepted key.
- `perr`  out  1  one-cycle pulse on a framing error, parity error, or timeout.

## Operation
- **Input conditioning**
  - Each PS/2 line passes through a 2-FF synchroniser.
  - `ps2_clk` is also filtered: its level changes only after 3 consecutive equal synchronised samples.
  - A falling edge of the filtered clock produces a one-cycle `fall` pulse. The data sample is taken on `fall`.
- **Frame FSM**: states IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear the bit counter. On `fall` with data=1, stay in IDLE with no `perr`.
  - DATA: shift 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: requires data=1 and odd parity over the 8 data bits plus the parity bit. If both hold, emit a one-cycle `byte_vld`. If either fails, pulse `perr` and discard the byte. Return to IDLE in both cases.
  - Timeout counter: reset on every `fall` and counts only outside IDLE. Reaching `TIMEOUT_CYC` pulses `perr`, discards the partial frame, and returns to IDLE.
- **Decoder** (scan code set 2; state flags `brk`, `ext`, `shift`):
  - 0xF0 sets `brk`. 0xE0 sets `ext`. Neither produces output.
  - 0x12 / 0x59 (L/R shift): `shift` ← `~brk`.
  - Any byte that is not a prefix clears `brk` and `ext` after it is processed.
  - If `brk`=1, the byte is a key release and produces no output.
  - If `ext`=1, only 0x5A (keypad Enter) maps, to 0x0D. Every other extended code is ignored.
  - Digits: 45/16/1E/26/25/2E/36/3D/3E/46 map to '0'..'9' (0x30–0x39). Digits are unaffected by shift.
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Lowercase when `shift`=0; uppercase (code − 0x20) when `shift`=1.
  - 0x29 maps to 0x20 (space). 0x5A maps to 0x0D (Enter). 0x66 maps to 0x08 (backspace).
  - Any other code produces no output, and `kB` is unchanged.
- **Output stage** (one-deep pending register):
  - On a mapped key with the strobe idle: load `kB`, raise `kclk`, and load the strobe counter with `STRB_CYC`.
  - On a mapped key while `kclk` is high: store the key as pending. When the strobe ends, `kclk` stays low for exactly 1 cycle, then the pending key is issued.
  - A third key arriving while one is already pending overwrites the pending key.
  - `kB` changes only in the cycle `kclk` rises. It is stable throughout the high phase.

## Timing
- Reset values: `kB`=0x00, `kclk`=0, `perr`=0. FSM in IDLE; `brk`=`ext`=`shift`=0; nothing pending; timeout counter at 0.
- `RST` asserted mid-frame or mid-strobe: everything returns to its reset value on the next edge, and any partial byte is lost.
- Edge detection: a raw `ps2_clk` fall is seen as `fall` 5 CLK cycles later (2 sync + 3 filter).
- Output latency: `fall` of the stop bit occurs in cycle N. `byte_vld` is asserted in N+1. `kB` and `kclk` are updated in N+2. `perr` is likewise asserted in N+1.
- A timeout fires exactly `TIMEOUT_CYC` cycles after the last `fall`.

## Test plan
- **Reset release**: after reset, send make code 0x16 with correct parity → `kB`=0x31, `kclk` high for 4 cycles, `perr` never asserted.
- **Release and shift**: send 12, 1C, F0 1C, F0 12, 1C → exactly two strobes, with `kB`=0x41 then 0x61. The breaks produce no strobes.
- **Bad frames**: send 0x45 with a flipped parity bit → `perr` pulses once, no strobe, `kB` unchanged. Repeat with stop bit=0 → same response.
- **Timeout**: stop `ps2_clk` after 4 data bits → `perr` exactly `TIMEOUT_CYC` cycles after the last edge. A following good 0x66 frame → `kB`=0x08.
- **Extended codes**: send E0 5A → `kB`=0x0D. Send E0 75 → no strobe. Send 0x0E (unmapped) → no strobe.
- **Back-to-back keys and reset**: inject a second decoded key while `kclk` is high (via a forced `byte_vld`) → one low cycle, then the second strobe. `RST` mid-frame → outputs 0, and the next clean frame decodes correctly.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw PS/2 lines, frames
// 11-bit packets, decodes scan code set 2 into ASCII and issues key strobes.
module ps2_kbd_rx #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned STRB_CYC    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kB,
  output logic       kclk,
  output logic       perr
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync, dat_sync, clk_hist;
  logic          filt, filt_d, fall, sdata;
  state_t        state, state_n;
  logic [7:0]    sr, rx_byte;
  logic [2:0]    bitcnt;
  logic          par, byte_vld, vld_n, perr_n, tmo;
  logic [TW-1:0] tcnt;
  logic          brk, ext, shift;
  logic          key_vld;
  logic [7:0]    key_code;
  logic [8:0]    mapped;
  logic [3:0]    scnt;
  logic          pend;
  logic [7:0]    pend_code;

  // Synchronise both lines; the clock level only flips after 3 equal samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_hist <= '1;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_hist <= {clk_hist[0], clk_sync[1]};
      if ({clk_hist, clk_sync[1]} == 3'b000)      filt <= 1'b0;
      else if ({clk_hist, clk_sync[1]} == 3'b111) filt <= 1'b1;
      filt_d   <= filt;
    end
  end

  assign fall  = filt_d & ~filt;
  assign sdata = dat_sync[1];
  // tcnt holds the number of cycles since the last fall while a frame is open
  assign tmo   = (state != S_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));

  // Frame FSM state register and receive datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      sr       <= '0;
      rx_byte  <= '0;
      bitcnt   <= '0;
      par      <= 1'b0;
      byte_vld <= 1'b0;
      perr     <= 1'b0;
      tcnt     <= '0;
    end else begin
      state    <= state_n;
      byte_vld <= vld_n;
      perr     <= perr_n;
      if (vld_n) rx_byte <= sr;
      if (fall) begin
        case (state)
          S_IDLE:   bitcnt <= '0;
          S_DATA: begin
            sr     <= {sdata, sr[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          S_PARITY: par <= sdata;
          default:  ;
        endcase
      end
      if (state_n == S_IDLE) tcnt <= '0;
      else if (fall)         tcnt <= TW'(1);
      else                   tcnt <= tcnt + TW'(1);
    end
  end

  // Frame FSM next-state, byte-valid and error decisions
  always_comb begin
    state_n = state;
    vld_n   = 1'b0;
    perr_n  = 1'b0;
    case (state)
      S_IDLE:   if (fall && !sdata) state_n = S_DATA;
      S_DATA:   if (fall && bitcnt == 3'd7) state_n = S_PARITY;
      S_PARITY: if (fall) state_n = S_STOP;
      S_STOP: begin
        if (fall) begin
          state_n = S_IDLE;
          if (sdata && (^{sr, par})) vld_n  = 1'b1;
          else                       perr_n = 1'b1;
        end
      end
      default:  state_n = S_IDLE;
    endcase
    if (tmo) begin
      state_n = S_IDLE;
      perr_n  = 1'b1;
    end
  end

  // Non-extended scan code to ASCII; bit 8 flags a mapped code
  function automatic logic [8:0] map_key(input logic [7:0] sc, input logic sh);
    logic [7:0] c;
    logic       v, letter;
    c      = '0;
    v      = 1'b1;
    letter = 1'b0;
    case (sc)
      8'h45: c = 8'h30;  8'h16: c = 8'h31;  8'h1E: c = 8'h32;  8'h26: c = 8'h33;
      8'h25: c = 8'h34;  8'h2E: c = 8'h35;  8'h36: c = 8'h36;  8'h3D: c = 8'h37;
      8'h3E: c = 8'h38;  8'h46: c = 8'h39;
      8'h29: c = 8'h20;  8'h5A: c = 8'h0D;  8'h66: c = 8'h08;
      8'h1C: begin c = 8'h61; letter = 1'b1; end
      8'h32: begin c = 8'h62; letter = 1'b1; end
      8'h21: begin c = 8'h63; letter = 1'b1; end
      8'h23: begin c = 8'h64; letter = 1'b1; end
      8'h24: begin c = 8'h65; letter = 1'b1; end
      8'h2B: begin c = 8'h66; letter = 1'b1; end
      8'h34: begin c = 8'h67; letter = 1'b1; end
      8'h33: begin c = 8'h68; letter = 1'b1; end
      8'h43: begin c = 8'h69; letter = 1'b1; end
      8'h3B: begin c = 8'h6A; letter = 1'b1; end
      8'h42: begin c = 8'h6B; letter = 1'b1; end
      8'h4B: begin c = 8'h6C; letter = 1'b1; end
      8'h3A: begin c = 8'h6D; letter = 1'b1; end
      8'h31: begin c = 8'h6E; letter = 1'b1; end
      8'h44: begin c = 8'h6F; letter = 1'b1; end
      8'h4D: begin c = 8'h70; letter = 1'b1; end
      8'h15: begin c = 8'h71; letter = 1'b1; end
      8'h2D: begin c = 8'h72; letter = 1'b1; end
      8'h1B: begin c = 8'h73; letter = 1'b1; end
      8'h2C: begin c = 8'h74; letter = 1'b1; end
      8'h3C: begin c = 8'h75; letter = 1'b1; end
      8'h2A: begin c = 8'h76; letter = 1'b1; end
      8'h1D: begin c = 8'h77; letter = 1'b1; end
      8'h22: begin c = 8'h78; letter = 1'b1; end
      8'h35: begin c = 8'h79; letter = 1'b1; end
      8'h1A: begin c = 8'h7A; letter = 1'b1; end
      default: v = 1'b0;
    endcase
    if (letter && sh) c = c - 8'h20;
    return {v, c};
  endfunction

  // Decode a received byte into a key event using the prefix/shift flags
  always_comb begin
    key_vld  = 1'b0;
    key_code = '0;
    mapped   = map_key(rx_byte, shift);
    if (byte_vld && !brk && rx_byte != 8'hF0 && rx_byte != 8'hE0) begin
      if (ext) begin
        if (rx_byte == 8'h5A) begin
          key_vld  = 1'b1;
          key_code = 8'h0D;
        end
      end else begin
        key_vld  = mapped[8];
        key_code = mapped[7:0];
      end
    end
  end

  // Prefix and shift flag tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      brk   <= 1'b0;
      ext   <= 1'b0;
      shift <= 1'b0;
    end else if (byte_vld) begin
      if (rx_byte == 8'hF0)      brk <= 1'b1;
      else if (rx_byte == 8'hE0) ext <= 1'b1;
      else begin
        if (rx_byte == 8'h12 || rx_byte == 8'h59) shift <= ~brk;
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

  // Strobe generator with a one-deep pending slot; a pending key issues after
  // exactly one low cycle because kclk drops on the last high cycle's edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      kB        <= '0;
      kclk      <= 1'b0;
      scnt      <= '0;
      pend      <= 1'b0;
      pend_code <= '0;
    end else if (kclk) begin
      if (scnt == 4'd1) kclk <= 1'b0;
      scnt <= scnt - 4'd1;
      if (key_vld) begin
        pend      <= 1'b1;
        pend_code <= key_code;
      end
    end else if (pend) begin
      kB   <= pend_code;
      kclk <= 1'b1;
      scnt <= 4'(STRB_CYC);
      pend <= key_vld;
      if (key_vld) pend_code <= key_code;
    end else if (key_vld) begin
      kB   <= key_code;
      kclk <= 1'b1;
      scnt <= 4'(STRB_CYC);
    end
  end

endmodule
